// File: rtl/mpu_pkg.sv
// Shared definitions for the sequential matrix-multiply unit: FSM states,
// accumulator sizing and the flattened-matrix element addressing helper.
package mpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Width needed to sum n products of two w-bit signed values with no loss.
  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction

  // Bit offset of element (r,c) inside a row-major flattened n x n matrix.
  function automatic int elem_off(input int w, input int n, input int r, input int c);
    return w * (c + n * r);
  endfunction

endpackage

// File: rtl/mpu_dot.sv
// One N-term signed dot product, reduced to W bits.
// Build option MPU_SAT_EN: when defined the sum saturates to the W-bit signed
// range and raises clamp; otherwise the sum wraps to its low W bits.
module mpu_dot
  import mpu_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic [W*N-1:0] a_row,
  input  logic [W*N-1:0] b_col,
  output logic [W-1:0]   y,
  output logic           clamp
);

  localparam int AW = acc_width(W, N);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] ext_a;
  logic signed [AW-1:0] ext_b;

  // Full-precision sum of products; operands are sign-extended to the
  // accumulator width first so no partial result is ever truncated.
  always_comb begin
    acc   = '0;
    ext_a = '0;
    ext_b = '0;
    for (int k = 0; k < N; k++) begin
      ext_a = {{(AW-W){a_row[k*W+W-1]}}, a_row[k*W +: W]};
      ext_b = {{(AW-W){b_col[k*W+W-1]}}, b_col[k*W +: W]};
      acc   = acc + ext_a * ext_b;
    end
  end

`ifdef MPU_SAT_EN
  localparam int MAXI = (1 << (W-1)) - 1;
  localparam logic signed [AW-1:0] MAXV = AW'(MAXI);
  localparam logic signed [AW-1:0] MINV = AW'(-MAXI - 1);

  // Clamp out-of-range sums to the representable extreme and flag it.
  always_comb begin
    y     = acc[W-1:0];
    clamp = 1'b0;
    if (acc > MAXV) begin
      y     = MAXV[W-1:0];
      clamp = 1'b1;
    end else if (acc < MINV) begin
      y     = MINV[W-1:0];
      clamp = 1'b1;
    end
  end
`else
  logic unused_hi;

  // Plain two's-complement wrap: keep the low W bits, never flag.
  assign y         = acc[W-1:0];
  assign clamp     = 1'b0;
  assign unused_hi = ^acc[AW-1:W];
`endif

endmodule

// File: rtl/mpu_matmul_seq.sv
// Sequential N x N signed matrix multiply, one result row per clock.
// Operands are captured on the accepting edge, so callers may change the
// inputs freely while a job runs. Build option MPU_SAT_EN selects
// saturating (with sticky overflow) instead of wrapping element reduction.
module mpu_matmul_seq
  import mpu_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [W*N*N-1:0] matrix_a,
  input  logic [W*N*N-1:0] matrix_b,
  output logic             ready,
  output logic             done,
  output logic [W*N*N-1:0] result,
  output logic             overflow
);

  localparam int MW = W * N * N;
  localparam int RW = $clog2(N);

  state_t         state;
  state_t         state_nx;
  logic [RW-1:0]  row;
  logic [MW-1:0]  a_q;
  logic [MW-1:0]  b_q;
  logic           accept;
  logic           step;
  logic           last_row;

  logic [W*N-1:0] a_row;
  logic [W*N-1:0] b_cols [N];
  logic [W*N-1:0] dot_y;
  logic [N-1:0]   dot_clamp;

  assign last_row = (row == RW'(N-1));
  assign ready    = (state != COMPUTE);
  assign done     = (state == DONE);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; accept marks a start taken, step marks a row write.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = COMPUTE;
        end
      end
      COMPUTE: begin
        step = 1'b1;
        if (last_row) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = COMPUTE;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture and row counter; the counter folds back to 0 after the
  // last row so it never addresses past the matrix.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
      row <= '0;
    end else if (accept) begin
      a_q <= matrix_a;
      b_q <= matrix_b;
      row <= '0;
    end else if (step) begin
      row <= last_row ? '0 : row + RW'(1);
    end
  end

  // Select the current row of the latched A operand.
  always_comb begin
    a_row = '0;
    for (int k = 0; k < N; k++) begin
      a_row[k*W +: W] = a_q[elem_off(W, N, int'(row), k) +: W];
    end
  end

  // Columns of B are fixed wiring; one dot-product unit per result column.
  for (genvar c = 0; c < N; c++) begin : g_col
    for (genvar k = 0; k < N; k++) begin : g_elem
      assign b_cols[c][k*W +: W] = b_q[elem_off(W, N, k, c) +: W];
    end

    mpu_dot #(
      .N (N),
      .W (W)
    ) u_dot (
      .a_row (a_row),
      .b_col (b_cols[c]),
      .y     (dot_y[c*W +: W]),
      .clamp (dot_clamp[c])
    );
  end

  // Result row write-back and sticky overflow; untouched rows hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result   <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      overflow <= 1'b0;
    end else if (step) begin
      for (int c = 0; c < N; c++) begin
        result[elem_off(W, N, int'(row), c) +: W] <= dot_y[c*W +: W];
      end
      overflow <= overflow | (|dot_clamp);
    end
  end

endmodule

// File: tb/tb_mpu_matmul_seq.sv
// Self-checking bench for mpu_matmul_seq (N=5, W=8). Expected results come
// from a behavioural matrix model, are queued when a job is launched and
// compared whenever done is observed. Honours MPU_SAT_EN like the design.
module tb_mpu_matmul_seq;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int MW = W * N * N;

  typedef struct {
    logic [MW-1:0] res;
    logic          ovf;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic [MW-1:0] matrix_a;
  logic [MW-1:0] matrix_b;
  logic          ready;
  logic          done;
  logic [MW-1:0] result;
  logic          overflow;

  exp_t expQ[$];
  exp_t monE;
  int   total     = 0;
  int   bad       = 0;
  int   cycle     = 0;
  int   doneCount = 0;
  int   accCycle  = 0;

  mpu_matmul_seq #(
    .N (N),
    .W (W)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .matrix_a (matrix_a),
    .matrix_b (matrix_b),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference C = A x B with the same element reduction as the build.
  function automatic exp_t model(input logic [MW-1:0] a, input logic [MW-1:0] b);
    exp_t                  e;
    longint                s;
    logic signed [W-1:0]   x;
    logic signed [W-1:0]   y;
    longint                maxv;
    longint                minv;
    maxv  = (longint'(1) <<< (W-1)) - 1;
    minv  = -maxv - 1;
    e.res = '0;
    e.ovf = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        s = 0;
        for (int k = 0; k < N; k++) begin
          x = a[W*(k+N*r) +: W];
          y = b[W*(c+N*k) +: W];
          s = s + longint'(x) * longint'(y);
        end
`ifdef MPU_SAT_EN
        if (s > maxv) begin
          s     = maxv;
          e.ovf = 1'b1;
        end else if (s < minv) begin
          s     = minv;
          e.ovf = 1'b1;
        end
`endif
        e.res[W*(c+N*r) +: W] = s[W-1:0];
      end
    end
    return e;
  endfunction

  function automatic logic [MW-1:0] randMat();
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < N*N; i++) m[W*i +: W] = W'($urandom);
    return m;
  endfunction

  function automatic logic [MW-1:0] fillMat(input logic [W-1:0] v);
    logic [MW-1:0] m;
    for (int i = 0; i < N*N; i++) m[W*i +: W] = v;
    return m;
  endfunction

  // Scoreboard side: every done pulse must match the oldest queued job.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      doneCount++;
      if (expQ.size() == 0) begin
        checkOutput("spurious_done", MW'(1), MW'(0));
      end else begin
        monE = expQ.pop_front();
        checkOutput("result", result, monE.res);
        checkOutput("overflow", MW'(overflow), MW'(monE.ovf));
      end
    end
  end

  // Present operands with start high; returns on the negedge after the
  // accepting posedge with start still high.
  task automatic applyStimulus(input logic [MW-1:0] a, input logic [MW-1:0] b, input bit expect_done);
    @(negedge clock);
    matrix_a = a;
    matrix_b = b;
    start    = 1'b1;
    if (expect_done) expQ.push_back(model(a, b));
    @(negedge clock);
    accCycle = cycle;
  endtask

  task automatic waitDone(input int expLat);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) checkOutput("done_timeout", MW'(0), MW'(1));
    else        checkOutput("latency", MW'(cycle - accCycle), MW'(expLat));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic [MW-1:0] p2;
    logic [MW-1:0] q2;
    int            d0;

    reset_n  = 1'b0;
    start    = 1'b0;
    matrix_a = '0;
    matrix_b = '0;
    #13;
    checkOutput("rst_ready", MW'(ready), MW'(1));
    checkOutput("rst_done", MW'(done), MW'(0));
    checkOutput("rst_result", result, '0);
    checkOutput("rst_overflow", MW'(overflow), MW'(0));
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // A = 1..25 row-major, B = identity.
    a = '0;
    b = '0;
    for (int i = 0; i < N*N; i++) a[W*i +: W] = W'(i + 1);
    for (int i = 0; i < N; i++)   b[W*(i+N*i) +: W] = W'(1);
    applyStimulus(a, b, 1'b1);
    start = 1'b0;
    checkOutput("busy_ready", MW'(ready), MW'(0));
    waitDone(N);
    checkOutput("ident_result", result, a);
    @(negedge clock);
    checkOutput("done_one_cycle", MW'(done), MW'(0));
    checkOutput("idle_ready", MW'(ready), MW'(1));

    // All -3 times all 4: every element is -60.
    applyStimulus(fillMat(W'(-3)), fillMat(W'(4)), 1'b1);
    start = 1'b0;
    waitDone(N);
    checkOutput("neg60_result", result, fillMat(W'(-60)));

    // All 127 times all 127: sum 80645 saturates or wraps to 5.
    applyStimulus(fillMat(W'(127)), fillMat(W'(127)), 1'b1);
    start = 1'b0;
    waitDone(N);
`ifdef MPU_SAT_EN
    checkOutput("big_result", result, fillMat(W'(127)));
    checkOutput("big_overflow", MW'(overflow), MW'(1));
`else
    checkOutput("big_result", result, fillMat(W'(5)));
    checkOutput("big_overflow", MW'(overflow), MW'(0));
`endif

    // Back-to-back with start held: each job spans N+1 cycles including DONE,
    // so the second done lands 2N+1 edges after the first accept.
    repeat (2) @(negedge clock);
    p2 = randMat();
    q2 = randMat();
    applyStimulus(randMat(), randMat(), 1'b1);
    @(negedge clock);
    matrix_a = p2;
    matrix_b = q2;
    expQ.push_back(model(p2, q2));
    waitDone(N);
    @(negedge clock);
    start    = 1'b0;
    matrix_a = randMat();
    matrix_b = randMat();
    waitDone(2*N + 1);
    repeat (3) @(negedge clock);
    checkOutput("queue_empty", MW'(expQ.size()), MW'(0));

    // Reset on the third COMPUTE edge abandons the job.
    applyStimulus(randMat(), randMat(), 1'b0);
    start = 1'b0;
    d0    = doneCount;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_result", result, '0);
    checkOutput("midrst_ready", MW'(ready), MW'(1));
    checkOutput("midrst_done", MW'(done), MW'(0));
    @(negedge clock);
    reset_n = 1'b1;
    repeat (8) @(negedge clock);
    checkOutput("midrst_no_done", MW'(doneCount - d0), MW'(0));
    applyStimulus(randMat(), randMat(), 1'b1);
    start = 1'b0;
    waitDone(N);

    // A start pulse with other operands during COMPUTE is ignored.
    repeat (2) @(negedge clock);
    d0 = doneCount;
    applyStimulus(randMat(), randMat(), 1'b1);
    start = 1'b0;
    @(negedge clock);
    matrix_a = randMat();
    matrix_b = randMat();
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    waitDone(N);
    repeat (8) @(negedge clock);
    checkOutput("ignored_start_dones", MW'(doneCount - d0), MW'(1));
    checkOutput("final_queue_empty", MW'(expQ.size()), MW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
